// File: rtl/mctl_wbuf.sv
// M-memory write buffer: posts destination writes into a small FIFO,
// drains them into RAM in idle cycles and forwards pending data to M-source reads.
module mctl_wbuf #(
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          state_decode,
    input  logic          state_write,
    input  logic          ir_mfield_n,
    input  logic [AW-1:0] ir_maddr,
    input  logic          destm,
    input  logic [AW-1:0] wadr,
    input  logic [DW-1:0] wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_re,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    output logic          srcm,
    output logic [DW-1:0] mdata,
    output logic          mdata_valid,
    output logic          mpass,
    output logic          wbuf_full,
    output logic          wbuf_ovf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          pend;
    logic [DW-1:0] hdata_q;
    logic [DW-1:0] mdata_q;
    logic          mpass_q;
    logic          ovf_q;

    logic          read_issue;
    logic          post;
    logic          drain;
    logic          accept;
    logic          hit;
    logic [DW-1:0] hit_data;
    logic [DW-1:0] mdata_mux;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign srcm       = ~ir_mfield_n;
    assign read_issue = state_decode & ~ir_mfield_n;
    assign post       = state_write & destm;
    assign wbuf_full  = (count == CW'(DEPTH));
    // Reads own the RAM port; the buffer only drains when no read is issued.
    assign drain      = ~read_issue & (count != '0);
    assign accept     = post & (~wbuf_full | drain);

    always_comb begin
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (reset_n) begin
            if (read_issue) begin
                ram_re   = 1'b1;
                ram_addr = ir_maddr;
            end else if (drain) begin
                ram_we    = 1'b1;
                ram_addr  = addr_q[rd_ptr];
                ram_wdata = data_q[rd_ptr];
            end
        end
    end

    // Walk oldest to newest so the newest matching entry wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            int            j;
            logic [PW-1:0] idx;
            j = int'(rd_ptr) + k;
            if (j >= DEPTH) j = j - DEPTH;
            idx = PW'(j);
            if (k < int'(count) && addr_q[idx] == ir_maddr) begin
                hit      = 1'b1;
                hit_data = data_q[idx];
            end
        end
    end

    assign mdata_mux   = mpass_q ? hdata_q : ram_rdata;
    assign mdata       = pend ? mdata_mux : mdata_q;
    assign mdata_valid = pend;
    assign mpass       = mpass_q;
    assign wbuf_ovf    = ovf_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q[wr_ptr] <= wadr;
            data_q[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ovf_q   <= 1'b0;
            pend    <= 1'b0;
            hdata_q <= '0;
            mpass_q <= 1'b0;
            mdata_q <= '0;
        end else begin
            if (accept) wr_ptr <= wrap_inc(wr_ptr);
            if (drain) rd_ptr <= wrap_inc(rd_ptr);
            if (accept && !drain) count <= count + 1'b1;
            else if (!accept && drain) count <= count - 1'b1;
            if (post && wbuf_full && !drain) ovf_q <= 1'b1;
            pend <= read_issue;
            if (read_issue) begin
                mpass_q <= hit;
                hdata_q <= hit_data;
            end
            if (pend) mdata_q <= mdata_mux;
        end
    end

endmodule

// File: tb/tb_mctl_wbuf.sv
// Directed bench for mctl_wbuf: forwarding, ordered drains, overflow
// and reset behaviour with hand-computed expected values.
module tb_mctl_wbuf;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        state_decode;
    logic        state_write;
    logic        ir_mfield_n;
    logic [4:0]  ir_maddr;
    logic        destm;
    logic [4:0]  wadr;
    logic [31:0] wdata;
    logic [31:0] ram_rdata;
    logic [4:0]  ram_addr;
    logic        ram_re;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic        srcm;
    logic [31:0] mdata;
    logic        mdata_valid;
    logic        mpass;
    logic        wbuf_full;
    logic        wbuf_ovf;

    logic [38:0] bus;
    logic [33:0] res;
    logic [38:0] eb;
    logic [33:0] er;
    int          nvec = 0;
    int          nerr = 0;

    assign bus = {ram_re, ram_we, ram_addr, ram_wdata};
    assign res = {mdata_valid, mpass, mdata};

    always #5 clk = ~clk;

    mctl_wbuf dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .state_decode (state_decode),
        .state_write  (state_write),
        .ir_mfield_n  (ir_mfield_n),
        .ir_maddr     (ir_maddr),
        .destm        (destm),
        .wadr         (wadr),
        .wdata        (wdata),
        .ram_rdata    (ram_rdata),
        .ram_addr     (ram_addr),
        .ram_re       (ram_re),
        .ram_we       (ram_we),
        .ram_wdata    (ram_wdata),
        .srcm         (srcm),
        .mdata        (mdata),
        .mdata_valid  (mdata_valid),
        .mpass        (mpass),
        .wbuf_full    (wbuf_full),
        .wbuf_ovf     (wbuf_ovf)
    );

    task automatic drive(input logic sd, input logic mfn, input logic [4:0] ma,
                         input logic sw, input logic dm, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] rd);
        state_decode = sd;
        ir_mfield_n  = mfn;
        ir_maddr     = ma;
        state_write  = sw;
        destm        = dm;
        wadr         = wa;
        wdata        = wd;
        ram_rdata    = rd;
        #1;
    endtask

    task automatic idle(input logic [31:0] rd);
        drive(1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, rd);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        idle(32'd0);
        nvec++;
        if (bus !== 39'd0) begin
            nerr++; $display("FAIL rst_bus got %h want 0", bus);
        end
        nvec++;
        if (res !== 34'd0) begin
            nerr++; $display("FAIL rst_res got %h want 0", res);
        end
        nvec++;
        if ({wbuf_full, wbuf_ovf, srcm} !== 3'b000) begin
            nerr++; $display("FAIL rst_flags got %b want 000", {wbuf_full, wbuf_ovf, srcm});
        end
        drive(1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 5'd3, 32'h1, 32'd0);
        nvec++;
        if ({srcm, bus} !== {1'b1, 39'd0}) begin
            nerr++; $display("FAIL rst_strobe got %h want %h", {srcm, bus}, {1'b1, 39'd0});
        end
        @(negedge clk);
        idle(32'd0);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward;
        drive(1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 32'd0);
        nvec++;
        if (bus !== 39'd0) begin
            nerr++; $display("FAIL fwd_post got %h want 0", bus);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        eb = {2'b10, 5'd3, 32'd0};
        nvec++;
        if (bus !== eb) begin
            nerr++; $display("FAIL fwd_read got %h want %h", bus, eb);
        end
        @(negedge clk);
        idle(32'hDEADBEEF);
        er = {2'b11, 32'hA5A5A5A5};
        nvec++;
        if (res !== er) begin
            nerr++; $display("FAIL fwd_data got %h want %h", res, er);
        end
        eb = {2'b01, 5'd3, 32'hA5A5A5A5};
        nvec++;
        if (bus !== eb) begin
            nerr++; $display("FAIL fwd_drain got %h want %h", bus, eb);
        end
        @(negedge clk);
        idle(32'd0);
        er = {2'b01, 32'hA5A5A5A5};
        nvec++;
        if ({bus, res} !== {39'd0, er}) begin
            nerr++; $display("FAIL fwd_hold got %h want %h", {bus, res}, {39'd0, er});
        end
        @(negedge clk);
    endtask

    task automatic test_same_addr;
        drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7, 32'd1, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 5'd7, 32'd2, 32'h0BAD0001);
        er = {2'b10, 32'h0BAD0001};
        nvec++;
        if (res !== er) begin
            nerr++; $display("FAIL same_miss got %h want %h", res, er);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 5'd0, 32'd0, 32'h0BAD0002);
        eb = {2'b10, 5'd7, 32'd0};
        nvec++;
        if ({wbuf_full, bus} !== {1'b1, eb}) begin
            nerr++; $display("FAIL same_full got %h want %h", {wbuf_full, bus}, {1'b1, eb});
        end
        @(negedge clk);
        idle(32'hFFFFFFFF);
        er = {2'b11, 32'd2};
        nvec++;
        if (res !== er) begin
            nerr++; $display("FAIL same_newest got %h want %h", res, er);
        end
        eb = {2'b01, 5'd7, 32'd1};
        nvec++;
        if (bus !== eb) begin
            nerr++; $display("FAIL same_drain1 got %h want %h", bus, eb);
        end
        @(negedge clk);
        idle(32'd0);
        eb = {2'b01, 5'd7, 32'd2};
        nvec++;
        if (bus !== eb) begin
            nerr++; $display("FAIL same_drain2 got %h want %h", bus, eb);
        end
        er = {2'b01, 32'd2};
        nvec++;
        if (res !== er) begin
            nerr++; $display("FAIL same_hold got %h want %h", res, er);
        end
        @(negedge clk);
        idle(32'd0);
        nvec++;
        if ({wbuf_full, bus} !== 40'd0) begin
            nerr++; $display("FAIL same_empty got %h want 0", {wbuf_full, bus});
        end
        @(negedge clk);
    endtask

    task automatic test_ram_read;
        drive(1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        eb = {2'b10, 5'd9, 32'd0};
        nvec++;
        if (bus !== eb) begin
            nerr++; $display("FAIL rd_issue got %h want %h", bus, eb);
        end
        @(negedge clk);
        idle(32'h12345678);
        er = {2'b10, 32'h12345678};
        nvec++;
        if ({bus, res} !== {39'd0, er}) begin
            nerr++; $display("FAIL rd_data got %h want %h", {bus, res}, {39'd0, er});
        end
        @(negedge clk);
        idle(32'hFFFFFFFF);
        er = {2'b00, 32'h12345678};
        nvec++;
        if (res !== er) begin
            nerr++; $display("FAIL rd_pulse got %h want %h", res, er);
        end
        @(negedge clk);
    endtask

    task automatic test_both;
        drive(1'b1, 1'b0, 5'd12, 1'b1, 1'b1, 5'd12, 32'h55, 32'd0);
        eb = {2'b10, 5'd12, 32'd0};
        nvec++;
        if (bus !== eb) begin
            nerr++; $display("FAIL both_issue got %h want %h", bus, eb);
        end
        @(negedge clk);
        idle(32'h77);
        er = {2'b10, 32'h77};
        nvec++;
        if (res !== er) begin
            nerr++; $display("FAIL both_nofwd got %h want %h", res, er);
        end
        eb = {2'b01, 5'd12, 32'h55};
        nvec++;
        if (bus !== eb) begin
            nerr++; $display("FAIL both_drain got %h want %h", bus, eb);
        end
        @(negedge clk);
        idle(32'd0);
        @(negedge clk);
    endtask

    task automatic test_full_drain;
        drive(1'b1, 1'b0, 5'd30, 1'b1, 1'b1, 5'd1, 32'hA, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 5'd2, 32'hB, 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd3, 32'hC, 32'd0);
        eb = {2'b01, 5'd1, 32'hA};
        nvec++;
        if ({wbuf_full, bus} !== {1'b1, eb}) begin
            nerr++; $display("FAIL fd_drain1 got %h want %h", {wbuf_full, bus}, {1'b1, eb});
        end
        @(negedge clk);
        idle(32'd0);
        eb = {2'b01, 5'd2, 32'hB};
        nvec++;
        if ({wbuf_full, wbuf_ovf, bus} !== {2'b10, eb}) begin
            nerr++; $display("FAIL fd_keep got %h want %h", {wbuf_full, wbuf_ovf, bus}, {2'b10, eb});
        end
        @(negedge clk);
        idle(32'd0);
        eb = {2'b01, 5'd3, 32'hC};
        nvec++;
        if ({wbuf_full, bus} !== {1'b0, eb}) begin
            nerr++; $display("FAIL fd_drain3 got %h want %h", {wbuf_full, bus}, {1'b0, eb});
        end
        @(negedge clk);
        idle(32'd0);
        nvec++;
        if (bus !== 39'd0) begin
            nerr++; $display("FAIL fd_empty got %h want 0", bus);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow;
        drive(1'b1, 1'b0, 5'd20, 1'b1, 1'b1, 5'd4, 32'h11, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd21, 1'b1, 1'b1, 5'd5, 32'h22, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd22, 1'b1, 1'b1, 5'd6, 32'h33, 32'd0);
        nvec++;
        if ({wbuf_full, wbuf_ovf} !== 2'b10) begin
            nerr++; $display("FAIL ovf_full got %b want 10", {wbuf_full, wbuf_ovf});
        end
        @(negedge clk);
        idle(32'd0);
        eb = {2'b01, 5'd4, 32'h11};
        nvec++;
        if ({wbuf_ovf, bus} !== {1'b1, eb}) begin
            nerr++; $display("FAIL ovf_set got %h want %h", {wbuf_ovf, bus}, {1'b1, eb});
        end
        @(negedge clk);
        idle(32'd0);
        eb = {2'b01, 5'd5, 32'h22};
        nvec++;
        if ({wbuf_ovf, bus} !== {1'b1, eb}) begin
            nerr++; $display("FAIL ovf_drain got %h want %h", {wbuf_ovf, bus}, {1'b1, eb});
        end
        @(negedge clk);
        idle(32'd0);
        nvec++;
        if ({wbuf_ovf, bus} !== {1'b1, 39'd0}) begin
            nerr++; $display("FAIL ovf_drop got %h want %h", {wbuf_ovf, bus}, {1'b1, 39'd0});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        drive(1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd8, 32'h1, 32'd0);
        @(negedge clk);
        drive(1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 5'd9, 32'h2, 32'hCAFE0000);
        @(negedge clk);
        reset_n = 1'b0;
        idle(32'hCAFE0001);
        nvec++;
        if ({wbuf_full, wbuf_ovf, bus, res} !== 75'd0) begin
            nerr++; $display("FAIL rm_async got %h want 0", {wbuf_full, wbuf_ovf, bus, res});
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(32'd0);
        nvec++;
        if (bus !== 39'd0) begin
            nerr++; $display("FAIL rm_release got %h want 0", bus);
        end
        @(negedge clk);
        idle(32'd0);
        nvec++;
        if ({wbuf_full, wbuf_ovf, bus, res} !== 75'd0) begin
            nerr++; $display("FAIL rm_clear got %h want 0", {wbuf_full, wbuf_ovf, bus, res});
        end
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd10, 32'h99, 32'd0);
        nvec++;
        if (bus !== 39'd0) begin
            nerr++; $display("FAIL rm_nothru got %h want 0", bus);
        end
        @(negedge clk);
        idle(32'd0);
        eb = {2'b01, 5'd10, 32'h99};
        nvec++;
        if (bus !== eb) begin
            nerr++; $display("FAIL rm_post got %h want %h", bus, eb);
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        idle(32'd0);
        @(negedge clk);
        test_reset;
        test_forward;
        test_same_addr;
        test_ram_read;
        test_both;
        test_full_drain;
        test_overflow;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mctl_wbuf.md
MCTL_WBUF -- requirements
Module: mctl_wbuf

Interface
REQ-001 Parameter AW, 5, M-memory address width.
REQ-002 Parameter DW, 32, M-memory data width.
REQ-003 Parameter DEPTH, 2, write-buffer entries; legal range 1..4.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 state_decode  in  1  decode-state strobe; an M-source read may be issued.
REQ-007 state_write  in  1  write-state strobe; a destination write may be posted.
REQ-008 ir_mfield_n  in  1  instruction A/M select bit; 0 = source is M-memory.
REQ-009 ir_maddr  in  AW  M source address from instruction.
REQ-010 destm  in  1  destination includes M-memory.
REQ-011 wadr  in  AW  write address.
REQ-012 wdata  in  DW  write data.
REQ-013 ram_rdata  in  DW  RAM read data, valid one cycle after ram_re.
REQ-014 ram_addr  out  AW  RAM address.
REQ-015 ram_re  out  1  RAM read strobe.
REQ-016 ram_we  out  1  RAM write strobe.
REQ-017 ram_wdata  out  DW  RAM write data.
REQ-018 srcm  out  1  combinational, = ~ir_mfield_n.
REQ-019 mdata  out  DW  M-source operand, registered.
REQ-020 mdata_valid  out  1  one-cycle pulse, mdata valid.
REQ-021 mpass  out  1  registered with mdata; 1 = operand forwarded from buffer.
REQ-022 wbuf_full  out  1  buffer holds DEPTH entries.
REQ-023 wbuf_ovf  out  1  sticky overflow error.

Function
REQ-024 Write buffer SHALL be a FIFO of DEPTH {addr, data} entries with valid count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-025 Post: state_write & destm SHALL enqueue {wadr, wdata} at the clock edge; no RAM access in that cycle for the post itself.
REQ-026 Read issue: state_decode & ~ir_mfield_n SHALL drive ram_re=1, ram_addr=ir_maddr, ram_we=0 in that cycle.
REQ-027 Forward check in the read-issue cycle SHALL compare ir_maddr with every valid entry; on hit, the newest matching entry's data SHALL be latched.
REQ-028 One cycle after read issue: mdata_valid=1; mdata = latched entry data with mpass=1 on hit, else ram_rdata with mpass=0; otherwise mdata_valid=0 and mdata/mpass hold.
REQ-029 Drain: in any cycle without read issue and count>0, the oldest entry SHALL be written: ram_we=1, ram_addr=entry addr, ram_wdata=entry data; entry retired at the edge.
REQ-030 Drain and post in the same cycle SHALL both occur; count unchanged; a post into a full buffer with simultaneous drain SHALL succeed.
REQ-031 A post into a full buffer without simultaneous drain SHALL be dropped and set wbuf_ovf=1 until reset.
REQ-032 A post with count 0 SHALL drain no earlier than the following cycle (no combinational write-through).
REQ-033 Idle: ram_re=ram_we=0, ram_addr=0, ram_wdata=0.
REQ-034 state_decode and state_write both high: read issue and post both proceed; drain suppressed; forward check excludes the entry being posted.
REQ-035 Entries to the same address SHALL NOT coalesce; each drains in order.
REQ-036 wbuf_full = (count==DEPTH), combinational from registered count.

Reset
REQ-037 reset_n low SHALL immediately clear count, pointers, wbuf_ovf, mdata_valid, mpass, mdata (0); RAM strobes 0 while reset_n low.
REQ-038 Reset mid-operation SHALL discard buffered writes and any in-flight read result; first post after release is stored in entry 0.

Verification
REQ-039 Post {3, 0xA5A5A5A5} then read addr 3 next cycle -> next cycle mdata=0xA5A5A5A5, mpass=1, ram_re=1 issued, no drain during read.
REQ-040 Posts to addr 7 values 1 then 2 (DEPTH=2), read addr 7 -> mdata=2, mpass=1; then two idle cycles -> ram_we writes 7<-1 then 7<-2.
REQ-041 Empty buffer, read addr 9 with ram_rdata=0x12345678 -> mdata=0x12345678, mpass=0, mdata_valid pulses one cycle.
REQ-042 DEPTH=2, fill via posts during consecutive reads, third post during read -> wbuf_full=1, post dropped, wbuf_ovf=1 and stays 1.
REQ-043 Full buffer, post in idle cycle -> drain and post same edge, count stays 2, wbuf_ovf=0.
REQ-044 Reset_n low with 2 entries pending -> count=0, no ram_we after release, wbuf_ovf=0, mdata=0.
